// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data/register widths, Mem control encoding
// and the MEM-stage access FSM states.
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Mem control field is {MemRead, MemWrite}; both set is treated as a read.
  localparam logic [1:0] MEM_RD = 2'b10;
  localparam logic [1:0] MEM_WR = 2'b01;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-cache request/stall bus between the MEM stage (master) and the
// data cache (slave).
interface mem_access_stage_if;
  import pipeline_pkg::*;

  logic              DCACHE_ren;
  logic              DCACHE_wen;
  logic [29:0]       DCACHE_addr;
  logic [DATA_W-1:0] DCACHE_wdata;
  logic [DATA_W-1:0] DCACHE_rdata;
  logic              DCACHE_stall;

  modport master (
    output DCACHE_ren, DCACHE_wen, DCACHE_addr, DCACHE_wdata,
    input  DCACHE_rdata, DCACHE_stall
  );

  modport slave (
    input  DCACHE_ren, DCACHE_wen, DCACHE_addr, DCACHE_wdata,
    output DCACHE_rdata, DCACHE_stall
  );

endinterface

// File: rtl/endian_swap32.sv
// Combinational 32-bit byte reverser; passes data through when ENABLE is 0.
module endian_swap32 #(
  parameter bit ENABLE = 1'b1
) (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = ENABLE ? {din[7:0], din[15:8], din[23:16], din[31:24]} : din;

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues data-cache loads/stores, freezes earlier stages
// while the cache stalls, and owns the MEM/WB register.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter bit SWAP_ENDIAN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WriteBack_3,
  input  logic [1:0]        Mem_3,
  input  logic [DATA_W-1:0] ALU_result_3,
  input  logic [DATA_W-1:0] writedata_3,
  input  logic [REG_W-1:0]  Rd_3,
  mem_access_stage_if.master dcache,
  output logic              memory_stall,
  output logic [DATA_W-1:0] writeback_data_5,
  output logic              WriteBack_5,
  output logic [REG_W-1:0]  Rd_5,
  output logic [CNT_W-1:0]  stall_cycles
);

  mem_state_e        state, next_state;
  logic              mem_read;
  logic              mem_write;
  logic              access;
  logic [DATA_W-1:0] rdata_sw;

  assign mem_read  = |(Mem_3 & MEM_RD);
  assign mem_write = |(Mem_3 & MEM_WR) & ~mem_read;
  assign access    = mem_read | mem_write;

  // Request lines are gated by rst so they drop the instant reset is raised.
  assign dcache.DCACHE_ren  = ~rst & mem_read;
  assign dcache.DCACHE_wen  = ~rst & mem_write;
  assign dcache.DCACHE_addr = ALU_result_3[31:2];
  assign memory_stall       = ~rst & access & dcache.DCACHE_stall;

  endian_swap32 #(.ENABLE(SWAP_ENDIAN)) u_wdata_swap (
    .din  (writedata_3),
    .dout (dcache.DCACHE_wdata)
  );

  endian_swap32 #(.ENABLE(SWAP_ENDIAN)) u_rdata_swap (
    .din  (dcache.DCACHE_rdata),
    .dout (rdata_sw)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets its default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (access && dcache.DCACHE_stall) next_state = WAIT;
      WAIT:    if (!dcache.DCACHE_stall)          next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // MEM/WB holds while stalled; re-writing the same value keeps forwarding valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeback_data_5 <= '0;
      WriteBack_5      <= 1'b0;
      Rd_5             <= '0;
    end else if (!memory_stall) begin
      writeback_data_5 <= mem_read ? rdata_sw : ALU_result_3;
      WriteBack_5      <= WriteBack_3;
      Rd_5             <= Rd_3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (memory_stall && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table of single-cycle accesses
// plus directed miss, saturation and reset sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        WriteBack_3;
  logic [1:0]  Mem_3;
  logic [31:0] ALU_result_3;
  logic [31:0] writedata_3;
  logic [4:0]  Rd_3;
  logic [31:0] rdata;
  logic        cstall;

  logic        memory_stall, memory_stall2;
  logic [31:0] writeback_data_5, writeback_data_52;
  logic        WriteBack_5, WriteBack_52;
  logic [4:0]  Rd_5, Rd_52;
  logic [31:0] stall_cycles;
  logic [1:0]  stall_cycles2;

  int checks   = 0;
  int failures = 0;

  mem_access_stage_if dc ();
  mem_access_stage_if dc2 ();

  assign dc.DCACHE_rdata  = rdata;
  assign dc.DCACHE_stall  = cstall;
  assign dc2.DCACHE_rdata = rdata;
  assign dc2.DCACHE_stall = cstall;

  mem_access_stage #(.SWAP_ENDIAN(1'b1), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .WriteBack_3      (WriteBack_3),
    .Mem_3            (Mem_3),
    .ALU_result_3     (ALU_result_3),
    .writedata_3      (writedata_3),
    .Rd_3             (Rd_3),
    .dcache           (dc.master),
    .memory_stall     (memory_stall),
    .writeback_data_5 (writeback_data_5),
    .WriteBack_5      (WriteBack_5),
    .Rd_5             (Rd_5),
    .stall_cycles     (stall_cycles)
  );

  // Second instance: no byte swap and a 2-bit counter to reach saturation.
  mem_access_stage #(.SWAP_ENDIAN(1'b0), .CNT_W(2)) dut2 (
    .clk              (clk),
    .rst              (rst),
    .WriteBack_3      (WriteBack_3),
    .Mem_3            (Mem_3),
    .ALU_result_3     (ALU_result_3),
    .writedata_3      (writedata_3),
    .Rd_3             (Rd_3),
    .dcache           (dc2.master),
    .memory_stall     (memory_stall2),
    .writeback_data_5 (writeback_data_52),
    .WriteBack_5      (WriteBack_52),
    .Rd_5             (Rd_52),
    .stall_cycles     (stall_cycles2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mem;
    logic        wb;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        cstall;
    logic        e_ren;
    logic        e_wen;
    logic [29:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_mstall;
    logic [31:0] e_wbdata;
    logic        e_wb5;
    logic [4:0]  e_rd5;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] mem, input logic wb, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] rd_data, input logic st);
    Mem_3        = mem;
    WriteBack_3  = wb;
    ALU_result_3 = alu;
    writedata_3  = wd;
    Rd_3         = rd;
    rdata        = rd_data;
    cstall       = st;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b1, 32'h0000_1234, 32'h0, 5'd5, 32'hDEAD_BEEF, 1'b0,
                1'b0, 1'b0, 30'h48D, 32'h0, 1'b0, 32'h0000_1234, 1'b1, 5'd5};
    vecs[1] = '{2'b10, 1'b1, 32'h0000_0100, 32'h0, 5'd7, 32'h7856_3412, 1'b0,
                1'b1, 1'b0, 30'h40, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 5'd7};
    vecs[2] = '{2'b01, 1'b0, 32'h0000_0204, 32'hAABB_CCDD, 5'd3, 32'h1111_1111, 1'b0,
                1'b0, 1'b1, 30'h81, 32'hDDCC_BBAA, 1'b0, 32'h0000_0204, 1'b0, 5'd3};
    vecs[3] = '{2'b11, 1'b1, 32'h0000_0FFC, 32'h5566_7788, 5'd31, 32'h0102_0304, 1'b0,
                1'b1, 1'b0, 30'h3FF, 32'h8877_6655, 1'b0, 32'h0403_0201, 1'b1, 5'd31};
    vecs[4] = '{2'b10, 1'b1, 32'h0000_0103, 32'h0, 5'd9, 32'hA0B0_C0D0, 1'b0,
                1'b1, 1'b0, 30'h40, 32'h0, 1'b0, 32'hD0C0_B0A0, 1'b1, 5'd9};
    // Cache stall with no request present must be ignored.
    vecs[5] = '{2'b00, 1'b1, 32'hCAFE_0000, 32'h0, 5'd2, 32'h0, 1'b1,
                1'b0, 1'b0, 30'h32BF_8000, 32'h0, 1'b0, 32'hCAFE_0000, 1'b1, 5'd2};

    rst = 1'b1;
    drive(2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    next_edge();
    check("reset_wbdata", writeback_data_5, 0);
    check("reset_wb5", WriteBack_5, 0);
    check("reset_rd5", Rd_5, 0);
    check("reset_stall_cycles", stall_cycles, 0);
    check("reset_ren", dc.DCACHE_ren, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].mem, vecs[i].wb, vecs[i].alu, vecs[i].wdata, vecs[i].rd,
            vecs[i].rdata, vecs[i].cstall);
      #2;
      check($sformatf("v%0d_ren", i), dc.DCACHE_ren, vecs[i].e_ren);
      check($sformatf("v%0d_wen", i), dc.DCACHE_wen, vecs[i].e_wen);
      check($sformatf("v%0d_addr", i), dc.DCACHE_addr, vecs[i].e_addr);
      check($sformatf("v%0d_wdata", i), dc.DCACHE_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d_mstall", i), memory_stall, vecs[i].e_mstall);
      next_edge();
      check($sformatf("v%0d_wbdata", i), writeback_data_5, vecs[i].e_wbdata);
      check($sformatf("v%0d_wb5", i), WriteBack_5, vecs[i].e_wb5);
      check($sformatf("v%0d_rd5", i), Rd_5, vecs[i].e_rd5);
    end
    check("hits_stall_cycles", stall_cycles, 0);

    // Load miss: three stalled cycles, MEM/WB holds the ALU op from vecs[5].
    drive(2'b10, 1'b1, 32'h0000_0300, 32'h0, 5'd12, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("ldmiss%0d_mstall", i), memory_stall, 1);
      check($sformatf("ldmiss%0d_ren", i), dc.DCACHE_ren, 1);
      check($sformatf("ldmiss%0d_addr", i), dc.DCACHE_addr, 30'hC0);
      next_edge();
      check($sformatf("ldmiss%0d_rd5_hold", i), Rd_5, 2);
      check($sformatf("ldmiss%0d_wbdata_hold", i), writeback_data_5, 32'hCAFE_0000);
    end
    check("ldmiss_stall_cycles", stall_cycles, 3);
    check("ldmiss_stall_cycles2", stall_cycles2, 3);
    cstall = 1'b0;
    rdata  = 32'h4433_2211;
    #2;
    check("ldmiss_done_mstall", memory_stall, 0);
    check("ldmiss_done_ren", dc.DCACHE_ren, 1);
    next_edge();
    check("ldmiss_wbdata", writeback_data_5, 32'h1122_3344);
    check("ldmiss_rd5", Rd_5, 12);
    check("ldmiss_wbdata_noswap", writeback_data_52, 32'h4433_2211);

    // Store miss: two stalled cycles; 2-bit counter must saturate, not wrap.
    drive(2'b01, 1'b0, 32'h0000_0400, 32'hAABB_CCDD, 5'd0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #2;
      check($sformatf("stmiss%0d_wen", i), dc.DCACHE_wen, 1);
      check($sformatf("stmiss%0d_ren", i), dc.DCACHE_ren, 0);
      check($sformatf("stmiss%0d_wdata", i), dc.DCACHE_wdata, 32'hDDCC_BBAA);
      check($sformatf("stmiss%0d_wdata_noswap", i), dc2.DCACHE_wdata, 32'hAABB_CCDD);
      check($sformatf("stmiss%0d_mstall", i), memory_stall, 1);
      next_edge();
      check($sformatf("stmiss%0d_rd5_hold", i), Rd_5, 12);
    end
    cstall = 1'b0;
    next_edge();
    check("stmiss_wb5", WriteBack_5, 0);
    check("stmiss_wbdata", writeback_data_5, 32'h0000_0400);
    check("stmiss_stall_cycles", stall_cycles, 5);
    check("stmiss_stall_cycles_sat", stall_cycles2, 3);

    // Reset raised while the FSM sits in WAIT.
    drive(2'b10, 1'b1, 32'h0000_0500, 32'h0, 5'd4, 32'h0, 1'b1);
    next_edge();
    #2;
    check("rstwait_pre_mstall", memory_stall, 1);
    rst = 1'b1;
    #1;
    check("rstwait_ren", dc.DCACHE_ren, 0);
    check("rstwait_mstall", memory_stall, 0);
    check("rstwait_stall_cycles", stall_cycles, 0);
    check("rstwait_stall_cycles2", stall_cycles2, 0);
    check("rstwait_rd5", Rd_5, 0);
    drive(2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    next_edge();
    rst = 1'b0;
    next_edge();
    check("postrst_wbdata", writeback_data_5, 0);
    check("postrst_wb5", WriteBack_5, 0);
    check("postrst_rd5", Rd_5, 0);
    check("postrst_stall_cycles", stall_cycles, 0);
    check("postrst_mstall", memory_stall, 0);

    // First access after reset completes as a same-cycle hit from IDLE.
    drive(2'b10, 1'b1, 32'h0000_0008, 32'h0, 5'd6, 32'h0D0C_0B0A, 1'b0);
    #2;
    check("postrst_hit_mstall", memory_stall, 0);
    next_edge();
    check("postrst_hit_wbdata", writeback_data_5, 32'h0A0B_0C0D);
    check("postrst_hit_rd5", Rd_5, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
